bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Sits directly upstream of the per-digit hex-to-7-segment decoders.
- Converts a binary result, such as a prime factor or GCD, into decimal digits. Each 4-bit output slice feeds one display decoder.
- Also produces a leading-zero mask so unused high digits can be blanked.

---
 rtl/bin_to_bcd_seq.sv | 144 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble).
// One iteration per clock: IN_WIDTH cycles of SHIFT, then a one-cycle FINISH
// that pulses done. The result digits, a sticky overflow flag and a
// leading-zero blanking mask are registered at completion. They hold until
// the next completion or reset.

module bin_to_bcd_seq #(
    parameter int IN_WIDTH = 16,
    parameter int DIGITS   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     lz_mask
);

    localparam int BCD_W = 4 * DIGITS;
    // The counter must be able to hold IN_WIDTH, the value it reaches after the last iteration.
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t              state;
    logic [IN_WIDTH-1:0] bin_sr;      // binary operand, consumed MSB first
    logic [BCD_W-1:0]    scratch;     // BCD digits under construction
    logic                sticky_ovf;  // a 1 has fallen off the top digit
    logic [CNT_W-1:0]    iter_cnt;    // iterations completed so far

    // Next-iteration values computed from the current state
    logic [BCD_W-1:0]    adj_scratch;
    logic [BCD_W-1:0]    next_scratch;
    logic [IN_WIDTH-1:0] next_bin;
    logic                carry_out;
    logic                next_ovf;
    logic [DIGITS-1:0]   next_lz;
    logic                higher_zero;

    // Add-3 correction: every digit >= 5 gets +3, independently of its neighbours
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path can leave
        // it unassigned and infer a latch.
        adj_scratch = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                adj_scratch[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    // Shift {scratch, binary} left by one and track bits lost off the top digit
    always_comb begin
        carry_out    = adj_scratch[BCD_W-1];
        next_scratch = {adj_scratch[BCD_W-2:0], bin_sr[IN_WIDTH-1]};
        next_bin     = bin_sr << 1;
        next_ovf     = sticky_ovf | carry_out;
    end

    // Leading-zero mask from the post-shift digits; digit 0 is never blanked
    always_comb begin
        next_lz     = '0;
        higher_zero = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            higher_zero = higher_zero & (next_scratch[4*d +: 4] == 4'd0);
            next_lz[d]  = higher_zero;
        end
        // A truncated result must be shown in full, so nothing is blanked on overflow.
        if (next_ovf) begin
            next_lz = '0;
        end
    end

    // Control FSM and datapath registers, with registered busy/done
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments. Every register then
        // samples the pre-edge values, whatever order the statements are written in.
        if (reset) begin
            // Reset clears the working registers as well as the outputs. An aborted
            // conversion therefore leaves nothing behind.
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd_out    <= '0;
            overflow   <= 1'b0;
            lz_mask    <= '0;
            bin_sr     <= '0;
            scratch    <= '0;
            sticky_ovf <= 1'b0;
            iter_cnt   <= '0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    // Accepting in FINISH as well as IDLE allows back-to-back
                    // conversions with no idle cycle between them.
                    done <= 1'b0;
                    if (start) begin
                        bin_sr     <= bin_in;
                        scratch    <= '0;
                        sticky_ovf <= 1'b0;
                        iter_cnt   <= '0;
                        state      <= SHIFT;
                        busy       <= 1'b1;
                    end else begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end

                SHIFT: begin
                    // start and bin_in are deliberately not looked at here.
                    bin_sr     <= next_bin;
                    scratch    <= next_scratch;
                    sticky_ovf <= next_ovf;
                    iter_cnt   <= iter_cnt + 1'b1;
                    if (iter_cnt == LAST_ITER) begin
                        bcd_out  <= next_scratch;
                        overflow <= next_ovf;
                        lz_mask  <= next_lz;
                        state    <= FINISH;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq
// Self-checking bench for bin_to_bcd_seq. It uses a 16-bit/5-digit instance
// and an 8-bit/2-digit instance. Expected digits, overflow and leading-zero
// masks come from a decimal model built with plain division.

module tb_bin_to_bcd_seq;

    logic        clk;
    logic        reset;

    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;
    logic        overflow;
    logic [4:0]  lz_mask;

    logic        start8;
    logic [7:0]  bin8;
    logic        busy8;
    logic        done8;
    logic [7:0]  bcd8;
    logic        ovf8;
    logic [1:0]  lz8;

    int tests_run;
    int tests_failed;

    bin_to_bcd_seq #(.IN_WIDTH(16), .DIGITS(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow),
        .lz_mask  (lz_mask)
    );

    bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) dut8 (
        .clk      (clk),
        .reset    (reset),
        .start    (start8),
        .bin_in   (bin8),
        .busy     (busy8),
        .done     (done8),
        .bcd_out  (bcd8),
        .overflow (ovf8),
        .lz_mask  (lz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    // Decimal reference: digit i = (v / 10^i) % 10. Overflow if v > 10^digits - 1.
    // Digit i (i >= 1) is a leading zero when v < 10^i and there is no overflow.
    function automatic void ref_model(input int unsigned v, input int digits,
                                      output logic [19:0] bcd, output logic ovf,
                                      output logic [4:0] lz);
        int unsigned p;
        bcd = '0;
        lz  = '0;
        p   = 1;
        for (int i = 0; i < digits; i++) begin
            bcd[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        ovf = (v >= p);
        p = 10;
        for (int i = 1; i < digits; i++) begin
            lz[i] = !ovf && (v < p);
            p = p * 10;
        end
    endfunction

    // Runs one conversion on the 16-bit instance.
    // lat is the edge count from the accepting edge (edge 1) to the first edge after which done is seen.
    task automatic convert16(input logic [15:0] v, output int lat, output int busy_n);
        start  = 1'b1;
        bin_in = v;
        lat    = -1;
        busy_n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic convert8(input logic [7:0] v, output int lat);
        start8 = 1'b1;
        bin8   = v;
        lat    = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 1) start8 = 1'b0;
            if (done8) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        start8 = 1'b0;
        bin8   = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, overflow} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: busy/done/ovf=%b expected 000", {busy, done, overflow});
        end
        tests_run++;
        if (bcd_out !== 20'h0 || lz_mask !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_data: bcd=%h lz=%b expected 00000/00000", bcd_out, lz_mask);
        end
        tests_run++;
        if ({busy8, done8, ovf8, bcd8, lz8} !== 13'b0) begin
            tests_failed++;
            $display("FAIL reset_dut8: got %b expected all zero", {busy8, done8, ovf8, bcd8, lz8});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        int lat, busy_n;
        convert16(16'd0, lat, busy_n);
        tests_run++;
        if (busy_n !== 16 || lat !== 17) begin
            tests_failed++;
            $display("FAIL zero_timing: busy cycles=%0d done edge=%0d expected 16/17", busy_n, lat);
        end
        tests_run++;
        if (bcd_out !== 20'h00000 || lz_mask !== 5'b11110 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_value: bcd=%h lz=%b ovf=%b expected 00000/11110/0",
                     bcd_out, lz_mask, overflow);
        end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_pulse: done=%b busy=%b a cycle later, expected 0/0", done, busy);
        end
    endtask

    task automatic test_known;
        logic [15:0] vals [4];
        logic [19:0] eb;
        logic        eo;
        logic [4:0]  el;
        int          lat, busy_n;
        vals = '{16'd65535, 16'd1234, 16'd9, 16'd10000};
        foreach (vals[n]) begin
            ref_model(vals[n], 5, eb, eo, el);
            convert16(vals[n], lat, busy_n);
            tests_run++;
            if (bcd_out !== eb || overflow !== eo || lz_mask !== el || lat !== 17) begin
                tests_failed++;
                $display("FAIL known_%0d: bcd=%h ovf=%b lz=%b edge=%0d expected %h/%b/%b/17",
                         vals[n], bcd_out, overflow, lz_mask, lat, eb, eo, el);
            end
        end
    endtask

    task automatic test_small_width;
        logic [7:0]  vals [5];
        logic [7:0]  v;
        logic [19:0] eb;
        logic        eo;
        logic [4:0]  el;
        int          lat;
        vals = '{8'd200, 8'd99, 8'd0, 8'd255, 8'd100};
        for (int n = 0; n < 25; n++) begin
            v = (n < 5) ? vals[n] : 8'($urandom_range(0, 255));
            ref_model(v, 2, eb, eo, el);
            convert8(v, lat);
            tests_run++;
            if (bcd8 !== eb[7:0] || ovf8 !== eo || lz8 !== el[1:0] || lat !== 9) begin
                tests_failed++;
                $display("FAIL w8_%0d: bcd=%h ovf=%b lz=%b edge=%0d expected %h/%b/%b/9",
                         v, bcd8, ovf8, lz8, lat, eb[7:0], eo, el[1:0]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int lat, busy_n;
        start  = 1'b1;
        bin_in = 16'd42;
        lat    = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1 || c == 4 || c == 11) start = 1'b0;
            if (c == 3 || c == 10) begin
                start  = 1'b1;
                bin_in = 16'd999;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        tests_run++;
        if (lat !== 17 || bcd_out !== 20'h00042 || lz_mask !== 5'b11100) begin
            tests_failed++;
            $display("FAIL ignore_busy: edge=%0d bcd=%h lz=%b expected 17/00042/11100",
                     lat, bcd_out, lz_mask);
        end
        // Start held during FINISH is accepted with no idle cycle.
        start  = 1'b1;
        bin_in = 16'd7;
        @(posedge clk); #1;
        start  = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL finish_start: busy=%b done=%b after FINISH edge, expected 1/0", busy, done);
        end
        lat    = -1;
        busy_n = 1;
        for (int c = 2; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
            if (busy) busy_n++;
        end
        tests_run++;
        if (lat !== 17 || busy_n !== 16 || bcd_out !== 20'h00007 || lz_mask !== 5'b11110) begin
            tests_failed++;
            $display("FAIL b2b_seven: edge=%0d busy=%0d bcd=%h lz=%b expected 17/16/00007/11110",
                     lat, busy_n, bcd_out, lz_mask);
        end
    endtask

    task automatic test_reset_abort;
        int saw_done;
        int lat, busy_n;
        saw_done = 0;
        start    = 1'b1;
        bin_in   = 16'd500;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (done) saw_done++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests_run++;
        if ({busy, done, overflow} !== 3'b000 || bcd_out !== 20'h0 || lz_mask !== 5'b0) begin
            tests_failed++;
            $display("FAIL abort_clear: busy=%b done=%b ovf=%b bcd=%h lz=%b expected all zero",
                     busy, done, overflow, bcd_out, lz_mask);
        end
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (done) saw_done++;
        end
        tests_run++;
        if (saw_done !== 0) begin
            tests_failed++;
            $display("FAIL abort_nodone: done pulses=%0d expected 0", saw_done);
        end
        convert16(16'd77, lat, busy_n);
        tests_run++;
        if (lat !== 17 || bcd_out !== 20'h00077 || lz_mask !== 5'b11100 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_recover: edge=%0d bcd=%h lz=%b ovf=%b expected 17/00077/11100/0",
                     lat, bcd_out, lz_mask, overflow);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] cur;
        logic [19:0] eb;
        logic        eo;
        logic [4:0]  el;
        int          cnt, n, busy_err;
        cur      = 16'($urandom_range(0, 65535));
        start    = 1'b1;
        bin_in   = cur;
        cnt      = 0;
        n        = 0;
        busy_err = 0;
        while (n < 500) begin
            @(posedge clk); #1;
            cnt++;
            if (done) begin
                ref_model(cur, 5, eb, eo, el);
                tests_run++;
                if (bcd_out !== eb || overflow !== eo || lz_mask !== el || cnt !== 17) begin
                    tests_failed++;
                    $display("FAIL b2b_%0d v=%0d: bcd=%h ovf=%b lz=%b edge=%0d expected %h/%b/%b/17",
                             n, cur, bcd_out, overflow, lz_mask, cnt, eb, eo, el);
                end
                cur    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 99))
                                                     : 16'($urandom_range(0, 65535));
                bin_in = cur;
                cnt    = 0;
                n++;
            end else begin
                if (!busy) busy_err++;
                // Changes to bin_in mid-conversion must have no effect.
                bin_in = 16'($urandom);
                if (cnt > 40) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL b2b_timeout: no done within 40 edges at conversion %0d", n);
                    break;
                end
            end
        end
        start = 1'b0;
        tests_run++;
        if (busy_err !== 0) begin
            tests_failed++;
            $display("FAIL b2b_busy: busy low outside FINISH %0d times, expected 0", busy_err);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_zero();
        test_known();
        test_small_width();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
